// File: rtl/dt_repack_pkg.sv
// Shared constants and state encoding for the distance-map repacker.
// Image geometry matches the distance-transform engine's 128x128 map.
package dt_repack_pkg;

  localparam int IMG_BITS = 14;
  localparam int IMG_SIDE = 128;
  localparam int NPIX     = 16384;
  localparam int NWORDS   = 1024;
  localparam int WORD_W   = 16;
  localparam int DIST_W   = 8;
  localparam int WADDR_W  = 10;
  localparam int CNT_W    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A zero threshold would mark background pixels as objects, so clamp it to 1.
  function automatic logic [DIST_W-1:0] fix_thresh(input logic [DIST_W-1:0] t);
    return (t == '0) ? DIST_W'(1) : t;
  endfunction

endpackage

// File: rtl/dt_repack_if.sv
// Memory-side bus of the repacker: result-RAM read port and packed-RAM write port.
interface dt_repack_if;
  import dt_repack_pkg::*;

  // res_rd qualifies res_addr and res_di must be valid combinationally in the same
  // cycle; sti_wr is a one-cycle write strobe with no backpressure (always accepted).
  logic                res_rd;
  logic [IMG_BITS-1:0] res_addr;
  logic [DIST_W-1:0]   res_di;
  logic                sti_wr;
  logic [WADDR_W-1:0]  sti_addr;
  logic [WORD_W-1:0]   sti_do;

  modport master (
    output res_rd, res_addr, sti_wr, sti_addr, sti_do,
    input  res_di
  );

  modport slave (
    input  res_rd, res_addr, sti_wr, sti_addr, sti_do,
    output res_di
  );

endinterface

// File: rtl/dt_repack_bitpack.sv
// Serial-to-parallel packer: collects 16 bits MSB-first and presents the full
// word combinationally alongside the 16th input bit.
module dt_bitpack
  import dt_repack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_in_valid,
  input  logic              i_in_bit,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  logic [3:0]        r_cnt;
  logic [WORD_W-2:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_in_valid) begin
      r_cnt <= r_cnt + 4'd1;
      r_sh  <= {r_sh[WORD_W-3:0], i_in_bit};
    end
  end

  assign o_word_valid = i_in_valid && (r_cnt == 4'd15);
  assign o_word       = {r_sh, i_in_bit};

endmodule

// File: rtl/dt_repack.sv
// Reads the distance map in raster order, thresholds each pixel, packs 16 pixels
// per word into the packed RAM, and reports maximum distance and object count.
module dt_repack
  import dt_repack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIST_W-1:0] thresh,
  dt_repack_if.master       bus,
  output logic [DIST_W-1:0] max_dist,
  output logic [CNT_W-1:0]  obj_cnt,
  output logic              done,
  output state_e            dbg_state
);

  state_e              r_state, w_next;
  logic [DIST_W-1:0]   r_thresh_q;
  logic                r_res_rd;
  logic [IMG_BITS-1:0] r_res_addr;
  logic                r_sti_wr;
  logic [WADDR_W-1:0]  r_sti_addr;
  logic [WORD_W-1:0]   r_sti_do;
  logic [DIST_W-1:0]   r_max;
  logic [CNT_W-1:0]    r_obj;
  logic                r_done;

  logic                w_accept, w_last_addr, w_consume, w_bit;
  logic                w_word_valid;
  logic [WORD_W-1:0]   w_word;

  assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_addr = (r_res_addr == IMG_BITS'(NPIX - 1));
  // res_rd being high means the pixel at res_addr is on res_di this cycle.
  assign w_consume   = r_res_rd;
  assign w_bit       = (bus.res_di >= r_thresh_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN:   if (w_last_addr) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  if (start) w_next = ST_RUN;
      default:  w_next = ST_IDLE;
    endcase
  end

  dt_bitpack u_bitpack (
    .clk          (clk),
    .rst_n        (reset),
    .i_clear      (w_accept),
    .i_in_valid   (w_consume),
    .i_in_bit     (w_bit),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_thresh_q <= '0;
      r_res_rd   <= 1'b0;
      r_res_addr <= '0;
      r_sti_wr   <= 1'b0;
      r_sti_addr <= '0;
      r_sti_do   <= '0;
      r_max      <= '0;
      r_obj      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_sti_wr <= w_word_valid;
      if (w_word_valid) begin
        r_sti_addr <= r_res_addr[IMG_BITS-1:4];
        r_sti_do   <= w_word;
      end
      if (w_accept) begin
        r_thresh_q <= fix_thresh(thresh);
        r_res_rd   <= 1'b1;
        r_res_addr <= '0;
        r_max      <= '0;
        r_obj      <= '0;
        r_done     <= 1'b0;
      end else begin
        if (r_state == ST_RUN) begin
          if (w_last_addr) r_res_rd   <= 1'b0;
          else             r_res_addr <= r_res_addr + IMG_BITS'(1);
        end
        if (w_consume) begin
          if (bus.res_di > r_max) r_max <= bus.res_di;
          r_obj <= r_obj + CNT_W'(w_bit);
        end
        if (r_state == ST_DRAIN) r_done <= 1'b1;
      end
    end
  end

  assign bus.res_rd   = r_res_rd;
  assign bus.res_addr = r_res_addr;
  assign bus.sti_wr   = r_sti_wr;
  assign bus.sti_addr = r_sti_addr;
  assign bus.sti_do   = r_sti_do;
  assign max_dist     = r_max;
  assign obj_cnt      = r_obj;
  assign done         = r_done;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_dt_repack.sv
// Scoreboard bench for dt_repack: a behavioural result RAM feeds the DUT and
// every packed-word write is checked against words computed from the map.
module tb_dt_repack;
  import dt_repack_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  thresh = 8'd0;
  logic [7:0]  max_dist;
  logic [14:0] obj_cnt;
  logic        done;
  state_e      dbg_state;

  logic [7:0]  map [NPIX];

  dt_repack_if bus ();
  assign bus.res_di = map[bus.res_addr];

  dt_repack dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .thresh    (thresh),
    .bus       (bus),
    .max_dist  (max_dist),
    .obj_cnt   (obj_cnt),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [7:0]  exp_max;
  logic [14:0] exp_obj;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent model: pixel b of word j lands at bit (15-b).
  task automatic push_expected(input logic [7:0] t);
    logic [7:0]  te;
    logic [15:0] w;
    logic [7:0]  p;
    te = (t == 8'd0) ? 8'd1 : t;
    exp_max = 8'd0;
    exp_obj = 15'd0;
    for (int j = 0; j < NWORDS; j++) begin
      w = 16'h0000;
      for (int b = 0; b < WORD_W; b++) begin
        p = map[j*WORD_W + b];
        if (p >= te) begin
          w[15-b] = 1'b1;
          exp_obj++;
        end
        if (p > exp_max) exp_max = p;
      end
      exp_q.push_back(w);
      exp_addr_q.push_back(j[9:0]);
    end
  endtask

  always @(negedge clk) begin
    if (bus.sti_wr === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'd1, 32'd0);
      end else begin
        chk("sti_do", bus.sti_do, exp_q.pop_front());
        chk("sti_addr", bus.sti_addr, exp_addr_q.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_res_rd"},   bus.res_rd,   0);
    chk({tag, "_res_addr"}, bus.res_addr, 0);
    chk({tag, "_sti_wr"},   bus.sti_wr,   0);
    chk({tag, "_sti_addr"}, bus.sti_addr, 0);
    chk({tag, "_sti_do"},   bus.sti_do,   0);
    chk({tag, "_max"},      max_dist,     0);
    chk({tag, "_obj"},      obj_cnt,      0);
    chk({tag, "_done"},     done,         0);
    chk({tag, "_state"},    dbg_state,    ST_IDLE);
  endtask

  // Drives the accept edge E0 and returns #1 after it; thresh is then scrambled.
  task automatic start_run(input logic [7:0] t);
    @(negedge clk);
    start  = 1'b1;
    thresh = t;
    @(posedge clk);
    #1;
    start  = 1'b0;
    thresh = 8'($urandom_range(0, 255));
    chk("e0_done_clr", done, 0);
    chk("e0_state", dbg_state, ST_RUN);
    chk("e0_res_rd", bus.res_rd, 1);
    chk("e0_res_addr", bus.res_addr, 0);
  endtask

  task automatic full_run(input logic [7:0] t);
    int n;
    exp_q.delete();
    exp_addr_q.delete();
    push_expected(t);
    wr_cnt = 0;
    start_run(t);
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_latency", n, 16385);
    chk("max_dist", max_dist, exp_max);
    chk("obj_cnt", obj_cnt, exp_obj);
    chk("wr_count", wr_cnt, 1024);
    chk("queue_left", exp_q.size(), 0);
    chk("end_res_rd", bus.res_rd, 0);
    chk("end_res_addr", bus.res_addr, 16383);
    chk("end_sti_wr", bus.sti_wr, 0);
    chk("end_state", dbg_state, ST_DONE);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_start", dbg_state, ST_IDLE);

    // All-zero map
    for (int k = 0; k < NPIX; k++) map[k] = 8'd0;
    full_run(8'd1);

    // One object pixel at the head of every word
    for (int k = 0; k < NPIX; k++) map[k] = (k % 16 == 0) ? 8'd1 : 8'd0;
    full_run(8'd1);

    // Row 64 = 5, row 65 = 2; then back-to-back with thresh 2 from DONE
    for (int k = 0; k < NPIX; k++) begin
      if (k / IMG_SIDE == 64)      map[k] = 8'd5;
      else if (k / IMG_SIDE == 65) map[k] = 8'd2;
      else                         map[k] = 8'd0;
    end
    full_run(8'd3);
    chk("rows_t3_obj", obj_cnt, 128);
    full_run(8'd2);
    chk("rows_t2_obj", obj_cnt, 256);

    // Zero threshold clamps to 1
    for (int k = 0; k < NPIX; k++) map[k] = 8'd1;
    full_run(8'd0);
    chk("t0_obj", obj_cnt, 15'h4000);

    // Random map with many 255s, thresh 255; mid-run start ignored, then reset
    for (int k = 0; k < NPIX; k++)
      map[k] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 254));
    exp_q.delete();
    exp_addr_q.delete();
    push_expected(8'd255);
    wr_cnt = 0;
    start_run(8'd255);
    repeat (99) @(posedge clk);
    #1;
    start  = 1'b1;
    thresh = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("midrun_state", dbg_state, ST_RUN);
    repeat (1899) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    chk("mid_wr_count", wr_cnt, 124);
    chk("mid_queue_left", exp_q.size(), NWORDS - 124);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check_reset_vals("post_rst");
    chk("post_rst_wr_count", wr_cnt, 124);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
